trivium_stream_gen: RTL and testbench
=====================================

Name: trivium_stream_gen

Overview:
- Parametrised Trivium keystream generator and successor to the fixed 64-bit Trivium wrapper driven by the autotest harness.
- Adds a configurable output width and a configurable number of state-update steps per cycle (unroll).
- Adds a configurable initialisation length, a valid/ready output handshake with backpressure, and a programmable block count.
- Sits between the autotest controller (key, IV, start, ready) and the SD result logger.

Parameters:
- DATA_WIDTH, 64, keystream bits per output block; must be a multiple of UNROLL.
- UNROLL, 1, Trivium steps per clock; allowed values 1..64; must divide DATA_WIDTH and 288*INIT_ROUNDS.
- INIT_ROUNDS, 4, warm-up length in units of 288 steps; output is discarded during warm-up.
- CNT_WIDTH, 16, width of the block counter and of num_blocks.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- key  in  80  key; K_i = key[i-1]
- iv  in  80  IV; IV_i = iv[i-1]
- num_blocks  in  CNT_WIDTH  blocks to emit; 0 = run until the next reset
- block_o  out  DATA_WIDTH  keystream block; first generated bit at bit 0
- valid_o  out  1  block_o is valid
- ready_i  in  1  consumer accepts the block when valid_o && ready_i
- busy_o  out  1  high in every state except IDLE
- end_block  out  1  one-cycle pulse after the last block is accepted

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; 288-bit state, counters and fill buffer cleared.
- FSM states: IDLE, LOAD, WARMUP, GEN, DONE.
- IDLE:
  - On start: latch key, iv and num_blocks; go to LOAD.
  - start in any other state is ignored.
- LOAD (1 cycle):
  - s1..s93 = K1..K80, then 13 zeros.
  - s94..s177 = IV1..IV80, then 4 zeros.
  - s178..s288 = 108 zeros, then 1,1,1.
- Step function, applied UNROLL times combinationally per enabled cycle:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
- WARMUP:
  - Lasts exactly 288*INIT_ROUNDS/UNROLL cycles; z is discarded.
  - Then go to GEN.
- GEN fill:
  - Each enabled cycle appends UNROLL z bits into the fill buffer, in step order, at increasing bit index.
  - After DATA_WIDTH/UNROLL cycles the buffer is full.
- GEN output:
  - When the buffer is full and the output register is empty, or is being accepted in that same cycle: transfer buffer to block_o, set valid_o, restart the fill.
  - When the buffer is full and the output register is held (valid_o && !ready_i): core and fill are stalled, with no step applied. No bit is lost or duplicated.
  - valid_o stays high and block_o stays stable until accepted.
  - Acceptance without a new block ready: valid_o <= 0 next cycle.
- Throughput: one block per DATA_WIDTH/UNROLL cycles with ready_i held high. UNROLL=DATA_WIDTH gives one block per cycle.
- Counting:
  - Each acceptance increments the block counter.
  - When counter == num_blocks (num_blocks != 0): go to DONE. The core does not advance further.
  - A partially filled buffer is dropped.
- DONE (1 cycle): end_block=1, busy_o=1; then IDLE with end_block=0 and busy_o=0.
- num_blocks=0: GEN runs indefinitely; the counter wraps silently and end_block is never asserted.
- First-valid latency, measured from the cycle start is sampled in IDLE: 1 + 288*INIT_ROUNDS/UNROLL + DATA_WIDTH/UNROLL cycles.
  - Defaults: 1217.
  - UNROLL=8: 153.
- Reset mid-operation: immediate return to the reset state. No end_block; a pending block is discarded.
- Changing key, iv or num_blocks after start has no effect; they are latched.

Test Plan:
- Defaults, key=0, iv=0, num_blocks=4, ready_i=1 → valid_o first high 1217 cycles after start. Four blocks at 64-cycle spacing match the golden C model, bit 0 = first keystream bit. end_block pulses once; busy_o drops the next cycle.
- UNROLL=64, DATA_WIDTH=64, key=80'h0123456789ABCDEF0123, iv=80'hFFFF0000FFFF0000FFFF, num_blocks=8 → same 8 blocks as with UNROLL=1. First valid at cycle 20. One block per cycle.
- Backpressure: ready_i low for 200 cycles after the first valid → block_o is stable and the core is stalled. The subsequent block sequence equals the no-stall sequence.
- rst pulled low 500 cycles into WARMUP, then a restart → all outputs 0 immediately. The restarted run produces output identical to a clean run.
- start pulsed during GEN and key changed after start → ignored; output is unaffected.
- num_blocks=0, 1000 blocks accepted → continuous valid blocks, no end_block, busy_o stays high.

Source files
------------

// File: rtl/trivium_stream_gen_if.sv
// Keystream output channel: block payload with valid/ready handshake.
// The producer holds block_o/valid_o stable until the consumer asserts ready_i.
interface trivium_stream_gen_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] block_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (output block_o, output valid_o, input ready_i);
  modport slave  (input block_o, input valid_o, output ready_i);
endinterface

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator, UNROLL steps/clk; first block 1+288*INIT_ROUNDS/UNROLL+DATA_WIDTH/UNROLL cycles after start.
// A held output block (valid_o && !ready_i) freezes the core and fill buffer so no keystream bit is lost.
module trivium_stream_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int UNROLL      = 1,
  parameter int INIT_ROUNDS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [79:0]          key,
  input  logic [79:0]          iv,
  input  logic [CNT_WIDTH-1:0] num_blocks,
  trivium_stream_gen_if.master strm,
  output logic                 busy_o,
  output logic                 end_block
);

  localparam int FILL_CYC = DATA_WIDTH / UNROLL;
  localparam int WARM_CYC = 288 * INIT_ROUNDS / UNROLL;
  localparam int FW       = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;
  localparam int WW       = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYC - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARM_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, GEN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [79:0]             key_q, iv_q;
  logic [CNT_WIDTH-1:0]    nb_q, blk_cnt, blk_cnt_inc;
  logic [287:0]            st, st_step;
  logic [288:0]            step_r;
  logic [UNROLL-1:0]       z_bits;
  logic [WW-1:0]           warm_cnt;
  logic [FW-1:0]           fill_cnt;
  logic [DATA_WIDTH-1:0]   fill_buf, fill_nxt, block_q;
  logic                    valid_q;
  logic                    accept, last_acc, out_free, fill_last;
  logic                    step_en, emit;

  // Bit i-1 of the vector holds Trivium state bit s_i; returns {z, next state}.
  function automatic logic [288:0] trv_step(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  always_comb begin
    st_step = st;
    step_r  = '0;
    z_bits  = '0;
    for (int j = 0; j < UNROLL; j++) begin
      step_r    = trv_step(st_step);
      z_bits[j] = step_r[288];
      st_step   = step_r[287:0];
    end
  end

  always_comb begin
    fill_nxt = fill_buf;
    for (int c = 0; c < FILL_CYC; c++) begin
      if (fill_cnt == FW'(c)) fill_nxt[c*UNROLL +: UNROLL] = z_bits;
    end
  end

  assign accept      = valid_q && strm.ready_i;
  assign blk_cnt_inc = blk_cnt + CNT_WIDTH'(1);
  assign last_acc    = accept && (nb_q != '0) && (blk_cnt_inc == nb_q);
  assign out_free    = !valid_q || strm.ready_i;
  assign fill_last   = (fill_cnt == FILL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LOAD;
      LOAD:   state_nxt = WARMUP;
      WARMUP: begin
        step_en = 1'b1;
        if (warm_cnt == WARM_LAST) state_nxt = GEN;
      end
      GEN: begin
        // The final acceptance ends the run before any further step.
        if (last_acc) begin
          state_nxt = DONE;
        end else begin
          step_en = !fill_last || out_free;
          emit    = fill_last && out_free;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q    <= '0;
      iv_q     <= '0;
      nb_q     <= '0;
      st       <= '0;
      warm_cnt <= '0;
      fill_cnt <= '0;
      fill_buf <= '0;
      block_q  <= '0;
      valid_q  <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      if (state == IDLE && start) begin
        key_q <= key;
        iv_q  <= iv;
        nb_q  <= num_blocks;
      end
      if (state == LOAD) begin
        st       <= {3'b111, 108'b0, 4'b0, iv_q, 13'b0, key_q};
        warm_cnt <= '0;
        fill_cnt <= '0;
        blk_cnt  <= '0;
      end else if (step_en) begin
        st <= st_step;
      end
      if (state == WARMUP) warm_cnt <= warm_cnt + WW'(1);
      // The last chunk goes straight into the output register with the buffer.
      if (state == GEN && step_en) begin
        if (emit) begin
          block_q  <= fill_nxt;
          fill_cnt <= '0;
        end else begin
          fill_buf <= fill_nxt;
          fill_cnt <= fill_cnt + FW'(1);
        end
      end
      if (accept) blk_cnt <= blk_cnt_inc;
      if (emit)        valid_q <= 1'b1;
      else if (accept) valid_q <= 1'b0;
    end
  end

  assign strm.block_o = block_q;
  assign strm.valid_o = valid_q;
  assign busy_o       = (state != IDLE);
  assign end_block    = (state == DONE);

endmodule

// File: tb/tb_trivium_stream_gen.sv
// Bench: UNROLL=1 and UNROLL=64 generators share stimulus; each accepted block is checked
// against a bit-serial Trivium reference held in per-instance expectation queues.
module tb_trivium_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [79:0] key = '0;
  logic [79:0] iv = '0;
  logic [15:0] nb = '0;
  logic        busy_a, busy_b, end_a, end_b;

  trivium_stream_gen_if #(.DATA_WIDTH(64)) ifa ();
  trivium_stream_gen_if #(.DATA_WIDTH(64)) ifb ();
  assign ifa.ready_i = ready;
  assign ifb.ready_i = ready;

  trivium_stream_gen #(.DATA_WIDTH(64), .UNROLL(1), .INIT_ROUNDS(4), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_n), .start(start), .key(key), .iv(iv), .num_blocks(nb),
    .strm(ifa), .busy_o(busy_a), .end_block(end_a));

  trivium_stream_gen #(.DATA_WIDTH(64), .UNROLL(64), .INIT_ROUNDS(4), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst_n), .start(start), .key(key), .iv(iv), .num_blocks(nb),
    .strm(ifb), .busy_o(busy_b), .end_block(end_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [63:0] qa[$];
  logic [63:0] qb[$];

  // Reference keystream, written straight from the s_1..s_288 formulation.
  task automatic model_push(input logic [79:0] k, input logic [79:0] v, input int n,
                            input bit to_a, input bit to_b);
    bit s[1:288];
    bit t1, t2, t3, z;
    logic [63:0] blk;
    int o;
    blk = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int i = 0; i < 1152 + n * 64; i++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int j = 288; j >= 179; j--) s[j] = s[j-1];
      s[178] = t2;
      for (int j = 177; j >= 95; j--) s[j] = s[j-1];
      s[94] = t1;
      for (int j = 93; j >= 2; j--) s[j] = s[j-1];
      s[1] = t3;
      if (i >= 1152) begin
        o = (i - 1152) % 64;
        blk[o] = z;
        if (o == 63) begin
          if (to_a) qa.push_back(blk);
          if (to_b) qb.push_back(blk);
        end
      end
    end
  endtask

  logic [63:0] blk_s[2];
  logic        vld_s[2], busy_s[2], end_s[2];
  assign blk_s[0] = ifa.block_o;  assign blk_s[1] = ifb.block_o;
  assign vld_s[0] = ifa.valid_o;  assign vld_s[1] = ifb.valid_o;
  assign busy_s[0] = busy_a;      assign busy_s[1] = busy_b;
  assign end_s[0] = end_a;        assign end_s[1] = end_b;

  int          acc_cnt[2] = '{0, 0};
  int          end_cnt[2] = '{0, 0};
  logic        hold[2] = '{1'b0, 1'b0};
  logic [63:0] held[2];
  logic        endp[2] = '{1'b0, 1'b0};

  // Output monitor: scoreboard pop on handshake, hold stability, end_block/busy sequencing.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        hold[d] <= 1'b0;
        endp[d] <= 1'b0;
      end else begin
        if (hold[d]) begin
          chk($sformatf("hold_valid%0d", d), 96'(vld_s[d]), 96'(1));
          chk($sformatf("hold_block%0d", d), 96'(blk_s[d]), 96'(held[d]));
        end
        hold[d] <= vld_s[d] && !ready;
        held[d] <= blk_s[d];
        if (vld_s[d] && ready) begin
          acc_cnt[d] <= acc_cnt[d] + 1;
          if (d == 0) begin
            chk("expect_pending0", 96'(qa.size() > 0), 96'(1));
            if (qa.size() > 0) begin
              chk("block0", 96'(blk_s[0]), 96'(qa[0]));
              void'(qa.pop_front());
            end
          end else begin
            chk("expect_pending1", 96'(qb.size() > 0), 96'(1));
            if (qb.size() > 0) begin
              chk("block1", 96'(blk_s[1]), 96'(qb[0]));
              void'(qb.pop_front());
            end
          end
        end
        if (endp[d]) begin
          chk($sformatf("busy_drop%0d", d), 96'(busy_s[d]), 96'(0));
          chk($sformatf("end_pulse%0d", d), 96'(end_s[d]), 96'(0));
        end
        if (end_s[d]) begin
          end_cnt[d] <= end_cnt[d] + 1;
          chk($sformatf("busy_done%0d", d), 96'(busy_s[d]), 96'(1));
        end
        endp[d] <= end_s[d];
      end
    end
  end

  // mode: 0 ready high, 1 stall after first A block, 2 random ready, 3 start+inputs changed mid-run
  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          nb;
    int          mode;
    int          stall;
    int          lat_a;
    int          lat_b;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int lat_a, lat_b, cyc, stall_left, e0, e1;
    qa.delete(); qb.delete();
    key = v.key; iv = v.iv; nb = 16'(v.nb); ready = 1'b1;
    model_push(v.key, v.iv, v.nb, 1'b1, 1'b1);
    e0 = end_cnt[0]; e1 = end_cnt[1];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start_a", 96'(busy_a), 96'(1));
    chk("busy_after_start_b", 96'(busy_b), 96'(1));
    lat_a = -1; lat_b = -1; cyc = 0; stall_left = 0;
    while (!(end_cnt[0] > e0 && end_cnt[1] > e1 && !busy_a && !busy_b) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (lat_a < 0 && ifa.valid_o) begin
        lat_a = cyc;
        if (v.mode == 1) stall_left = v.stall;
      end
      if (lat_b < 0 && ifb.valid_o) begin
        lat_b = cyc;
        if (v.mode == 3) begin
          key = ~key; iv = ~iv; nb = 16'd1; start = 1'b1;
        end
      end
      if (v.mode == 2) ready = 1'($urandom_range(0, 1));
      else             ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("run_timeout", 96'(cyc < 20000), 96'(1));
    chk("latency_a", 96'(lat_a), 96'(v.lat_a));
    chk("latency_b", 96'(lat_b), 96'(v.lat_b));
    chk("end_count_a", 96'(end_cnt[0] - e0), 96'(1));
    chk("end_count_b", 96'(end_cnt[1] - e1), 96'(1));
    chk("left_a", 96'(qa.size()), 96'(0));
    chk("left_b", 96'(qb.size()), 96'(0));
  endtask

  initial begin
    int base, cyc, e0, e1;
    vecs[0] = '{80'h0, 80'h0, 4, 0, 0, 1217, 20};
    vecs[1] = '{80'h0123456789ABCDEF0123, 80'hFFFF0000FFFF0000FFFF, 8, 0, 0, 1217, 20};
    vecs[2] = '{80'hA5A5123456789ABCDEF0, 80'h0F0F00FF123400005555, 3, 1, 200, 1217, 20};
    vecs[3] = '{80'h13579BDF02468ACE1111, 80'h8000000000000000000F, 5, 2, 0, 1217, 20};
    vecs[4] = '{80'hDEADBEEFCAFEF00D7777, 80'h0000000000000000ABCD, 3, 3, 0, 1217, 20};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), 96'(vld_s[d]), 96'(0));
      chk($sformatf("rst_block%0d", d), 96'(blk_s[d]), 96'(0));
      chk($sformatf("rst_busy%0d", d), 96'(busy_s[d]), 96'(0));
      chk($sformatf("rst_end%0d", d), 96'(end_s[d]), 96'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset 500 cycles in: A still warming up, B holding an unaccepted block.
    qa.delete(); qb.delete();
    key = 80'h55555555555555555555; iv = 80'h1; nb = 16'd0; ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("pre_rst_busy_a", 96'(busy_a), 96'(1));
    chk("pre_rst_valid_b", 96'(ifb.valid_o), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", 96'(busy_a), 96'(0));
    chk("mid_rst_busy_b", 96'(busy_b), 96'(0));
    chk("mid_rst_valid_b", 96'(ifb.valid_o), 96'(0));
    chk("mid_rst_block_b", 96'(ifb.block_o), 96'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // Unbounded run: B delivers 1000 blocks, no end_block.
    qa.delete(); qb.delete();
    key = vecs[1].key; iv = vecs[1].iv; nb = 16'd0; ready = 1'b1;
    model_push(key, iv, 1000, 1'b0, 1'b1);
    base = acc_cnt[1]; e0 = end_cnt[0]; e1 = end_cnt[1];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (acc_cnt[1] - base < 1000 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b0;
    @(posedge clk); #1;
    chk("free_run_blocks", 96'(acc_cnt[1] - base), 96'(1000));
    chk("free_run_busy_a", 96'(busy_a), 96'(1));
    chk("free_run_busy_b", 96'(busy_b), 96'(1));
    chk("free_run_no_end_a", 96'(end_cnt[0] - e0), 96'(0));
    chk("free_run_no_end_b", 96'(end_cnt[1] - e1), 96'(0));
    chk("free_run_left_b", 96'(qb.size()), 96'(0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
